// File: rtl/counter.sv
// -----------------------------------------------------------------------------
// counter
//
// Start-triggered cycle counter for the MMU datapath. A one-cycle start_i
// request arms the block. It then counts COUNT_NUM clock cycles and raises
// done_o for exactly one cycle. This is a control-side helper and carries no
// data.
//
// Parameters:
//   COUNT_NUM : number of clock cycles from an accepted start to done_o
//               (legal range 1..65535)
//   CNT_W     : (localparam) width of the internal cycle counter
//
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset (IDLE, cnt=0, done_o=0)
//   start_i : start request, sampled on the rising clk edge
//   done_o  : registered completion pulse, one cycle wide
//
// Build option:
//   COUNTER_RETRIGGER_EN : when defined, start_i in RUN or DONE restarts the
//                          count, so done_o fires COUNT_NUM cycles after the
//                          latest accepted start. When undefined, start_i is
//                          ignored outside IDLE.
// -----------------------------------------------------------------------------
module counter #(
  parameter int COUNT_NUM = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic done_o
);

  localparam int CNT_W = $clog2(COUNT_NUM + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(COUNT_NUM);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // With a one-cycle count there is nothing to time, so an accepted start
  // jumps straight to DONE and RUN is never entered.
  localparam bit ONE_SHOT = (COUNT_NUM == 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  // The output comes straight from a flop, so there is no combinational
  // path from start_i to done_o.
  assign done_o = r_done;

  // Single state machine. It holds the state, the cycle counter and the
  // registered done pulse.
  // In RUN the counter holds the number of cycles since the accepting edge.
  // When it reaches COUNT_NUM on an edge, that edge moves the machine to
  // DONE and raises done_o.
  // The unused encoding 2'b11 falls into the default branch and recovers to
  // IDLE with done_o low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= CNT_ZERO;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            if (ONE_SHOT) begin
              r_state <= DONE;
              r_cnt   <= CNT_ZERO;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_cnt   <= CNT_ONE;
              r_done  <= 1'b0;
            end
          end else begin
            r_state <= IDLE;
            r_cnt   <= CNT_ZERO;
            r_done  <= 1'b0;
          end
        end

        RUN: begin
`ifdef COUNTER_RETRIGGER_EN
          // A fresh start has priority over finishing. It restarts the
          // count from the accepting edge.
          if (start_i) begin
            r_state <= RUN;
            r_cnt   <= CNT_ONE;
            r_done  <= 1'b0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= DONE;
            r_cnt   <= CNT_ZERO;
            r_done  <= 1'b1;
          end else begin
            r_state <= RUN;
            r_cnt   <= r_cnt + CNT_ONE;
            r_done  <= 1'b0;
          end
`else
          if (r_cnt == CNT_MAX) begin
            r_state <= DONE;
            r_cnt   <= CNT_ZERO;
            r_done  <= 1'b1;
          end else begin
            r_state <= RUN;
            r_cnt   <= r_cnt + CNT_ONE;
            r_done  <= 1'b0;
          end
`endif
        end

        DONE: begin
`ifdef COUNTER_RETRIGGER_EN
          // Restarting out of DONE cuts nothing short, because done_o has
          // already been high for this whole cycle.
          if (start_i) begin
            if (ONE_SHOT) begin
              r_state <= DONE;
              r_cnt   <= CNT_ZERO;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_cnt   <= CNT_ONE;
              r_done  <= 1'b0;
            end
          end else begin
            r_state <= IDLE;
            r_cnt   <= CNT_ZERO;
            r_done  <= 1'b0;
          end
`else
          r_state <= IDLE;
          r_cnt   <= CNT_ZERO;
          r_done  <= 1'b0;
`endif
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= CNT_ZERO;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter.sv
// -----------------------------------------------------------------------------
// tb_counter
//
// Directed testbench for counter.
//
// dut    : COUNT_NUM = 16 (the main configuration)
// dutOne : COUNT_NUM = 1  (the single-cycle path that skips RUN)
//
// Inputs are driven at the falling edge. Each loop iteration j drives the
// inputs for rising edge j, then observes done_o at the following falling
// edge, which is after edge j has taken effect.
// -----------------------------------------------------------------------------
module tb_counter;

  logic clk;
  logic rst_n;
  logic startIn;
  logic doneOut;
  logic startOne;
  logic doneOne;

  int testsRun;
  int testsFailed;

  counter #(.COUNT_NUM(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (startIn),
    .done_o  (doneOut)
  );

  counter #(.COUNT_NUM(1)) dutOne (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (startOne),
    .done_o  (doneOne)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop, so the run always ends even if something goes wrong.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Hold reset for three cycles with start toggling. Then check that done_o
  // drops asynchronously when reset is asserted during the done pulse.
  task automatic test_reset();
    rst_n    = 1'b0;
    startOne = 1'b0;
    for (int j = 0; j < 3; j++) begin
      startIn = j[0];
      @(negedge clk);
      testsRun++;
      if (doneOut !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL reset_hold cyc %0d: done_o=%b expected 0", j, doneOut);
      end
    end
    startIn = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);

    // Run up to the done cycle.
    for (int j = 0; j <= 16; j++) begin
      startIn = (j == 0);
      @(negedge clk);
    end
    testsRun++;
    if (doneOut !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_pre_async: done_o=%b expected 1", doneOut);
    end

    // Assert reset away from any clock edge. done_o must fall without a clock.
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (doneOut !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_async: done_o=%b expected 0", doneOut);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      testsRun++;
      if (doneOut !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL reset_after cyc %0d: done_o=%b expected 0", j, doneOut);
      end
    end
  endtask

  // A single start pulse at edge 0. done_o must be high only after edge 16,
  // then stay low for the three idle cycles that follow.
  task automatic test_single_start();
    for (int j = 0; j <= 19; j++) begin
      startIn = (j == 0);
      @(negedge clk);
      testsRun++;
      if (doneOut !== (j == 16)) begin
        testsFailed++;
        $display("[TB] FAIL single_start cyc %0d: done_o=%b expected %b", j, doneOut, (j == 16));
      end
    end
  endtask

  // Two runs. The second start comes three cycles after the first done pulse.
  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int j = 0; j <= 40; j++) begin
      startIn = (j == 0) || (j == 19);
      @(negedge clk);
      if (doneOut === 1'b1) pulses++;
      testsRun++;
      if (doneOut !== ((j == 16) || (j == 35))) begin
        testsFailed++;
        $display("[TB] FAIL back_to_back cyc %0d: done_o=%b expected %b", j, doneOut, ((j == 16) || (j == 35)));
      end
    end
    testsRun++;
    if (pulses != 2) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back_pulses: got %0d expected 2", pulses);
    end
  endtask

  // An extra start at edge 5 while the block is running.
  task automatic test_ignored_start();
    int pulses;
    int doneCyc;
    pulses = 0;
`ifdef COUNTER_RETRIGGER_EN
    doneCyc = 21;
`else
    doneCyc = 16;
`endif
    for (int j = 0; j <= 25; j++) begin
      startIn = (j == 0) || (j == 5);
      @(negedge clk);
      if (doneOut === 1'b1) pulses++;
      testsRun++;
      if (doneOut !== (j == doneCyc)) begin
        testsFailed++;
        $display("[TB] FAIL ignored_start cyc %0d: done_o=%b expected %b", j, doneOut, (j == doneCyc));
      end
    end
    testsRun++;
    if (pulses != 1) begin
      testsFailed++;
      $display("[TB] FAIL ignored_start_pulses: got %0d expected 1", pulses);
    end
  endtask

  // Hold start high for 60 edges (edges 0..59), then keep watching until the
  // final run completes.
  task automatic test_continuous();
    logic expDone;
    for (int j = 0; j <= 78; j++) begin
      startIn = (j < 60);
      @(negedge clk);
`ifdef COUNTER_RETRIGGER_EN
      expDone = (j == 75);
`else
      expDone = (j == 16) || (j == 34) || (j == 52) || (j == 70);
`endif
      testsRun++;
      if (doneOut !== expDone) begin
        testsFailed++;
        $display("[TB] FAIL continuous cyc %0d: done_o=%b expected %b", j, doneOut, expDone);
      end
    end
    startIn = 1'b0;
  endtask

  // Reset pulse at edge 8 of a run. No done pulse may appear, and a fresh
  // start afterwards must still give done 16 cycles later.
  task automatic test_reset_mid_run();
    for (int j = 0; j <= 25; j++) begin
      startIn = (j == 0);
      if (j == 8) rst_n = 1'b0;
      if (j == 9) rst_n = 1'b1;
      @(negedge clk);
      testsRun++;
      if (doneOut !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL reset_mid_run cyc %0d: done_o=%b expected 0", j, doneOut);
      end
    end
    for (int j = 0; j <= 17; j++) begin
      startIn = (j == 0);
      @(negedge clk);
      testsRun++;
      if (doneOut !== (j == 16)) begin
        testsFailed++;
        $display("[TB] FAIL restart_after_reset cyc %0d: done_o=%b expected %b", j, doneOut, (j == 16));
      end
    end
  endtask

  // COUNT_NUM = 1. done_o rises on the accepting edge itself and lasts one cycle.
  task automatic test_count_one();
    for (int j = 0; j <= 3; j++) begin
      startOne = (j == 0);
      @(negedge clk);
      testsRun++;
      if (doneOne !== (j == 0)) begin
        testsFailed++;
        $display("[TB] FAIL count_one cyc %0d: done_o=%b expected %b", j, doneOne, (j == 0));
      end
    end
    startOne = 1'b0;
  endtask

  // Run every scenario in sequence, then print the summary.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    startIn     = 1'b0;
    startOne    = 1'b0;
    @(negedge clk);

    test_reset();
    test_single_start();
    test_back_to_back();
    test_ignored_start();
    test_continuous();
    test_reset_mid_run();
    test_count_one();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
